// File: rtl/warp_regfile_param.sv
// Per-warp, per-lane SIMD register file: two registered read ports, one lane-masked
// write port, optional write-to-read forwarding and a post-reset zeroing sequencer.
module warp_regfile_param #(
  parameter int NUM_WARPS = 16,
  parameter int NUM_LANES = 16,
  parameter int NUM_REGS  = 16,
  parameter int DATA_W    = 32,
  parameter int BYPASS    = 1,
  localparam int WW       = $clog2(NUM_WARPS),
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          busy,
  input  logic [NUM_LANES-1:0]          read_en_0,
  input  logic [NUM_LANES-1:0]          read_en_1,
  input  logic [AW-1:0]                 raddr_0,
  input  logic [AW-1:0]                 raddr_1,
  input  logic [WW-1:0]                 rwarp,
  input  logic [NUM_LANES-1:0]          write_en,
  input  logic [AW-1:0]                 waddr,
  input  logic [WW-1:0]                 wwarp,
  input  logic [NUM_LANES*DATA_W-1:0]   wdata,
  output logic [NUM_LANES*DATA_W-1:0]   rdata_0,
  output logic [NUM_LANES*DATA_W-1:0]   rdata_1,
  output logic                          rvalid_0,
  output logic                          rvalid_1
);

  localparam int CW      = WW + AW;
  localparam int NUM_ROWS = NUM_WARPS * NUM_REGS;
  localparam int LW      = NUM_LANES * DATA_W;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [CW-1:0]          cnt_r;
  logic                   busy_r;
  logic                   clr_s;
  logic [NUM_LANES-1:0]   wr_s;
  logic [CW-1:0]          wrow_s;

  logic [DATA_W-1:0]      mem_r [NUM_ROWS][NUM_LANES];

  logic [NUM_LANES-1:0]   ren_s   [2];
  logic [AW-1:0]          raddr_s [2];
  logic [CW-1:0]          rrow_s  [2];
  logic [LW-1:0]          rnext_s [2];
  logic [LW-1:0]          rdata_r [2];
  logic                   rvalid_r [2];

  // Next-state logic: leave CLEAR once the last row has been zeroed
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == {CW{1'b1}}) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_READY: state_s = ST_READY;
      default:  state_s = ST_CLEAR;
    endcase
  end

  // State, clear counter and busy flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_CLEAR);
      if (state_r == ST_CLEAR) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Write qualification: sequencer owns the array while clearing
  always_comb begin
    clr_s  = (state_r == ST_CLEAR);
    wrow_s = {wwarp, waddr};
    if (!rst && (state_r == ST_READY)) begin
      wr_s = write_en;
    end else begin
      wr_s = {NUM_LANES{1'b0}};
    end
  end

  // Storage array: whole-row zeroing during CLEAR, lane-masked writes otherwise
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (clr_s) begin
        mem_r[cnt_r][i] <= {DATA_W{1'b0}};
      end else if (wr_s[i]) begin
        mem_r[wrow_s][i] <= wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read data selection, forwarding same-row same-lane write data when enabled
  always_comb begin
    ren_s[0]   = read_en_0;
    ren_s[1]   = read_en_1;
    raddr_s[0] = raddr_0;
    raddr_s[1] = raddr_1;
    for (int p = 0; p < 2; p++) begin
      rrow_s[p]  = {rwarp, raddr_s[p]};
      rnext_s[p] = {LW{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
        if ((BYPASS != 0) && write_en[i] && (rwarp == wwarp) && (raddr_s[p] == waddr)) begin
          rnext_s[p][i*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
        end else begin
          rnext_s[p][i*DATA_W +: DATA_W] = mem_r[rrow_s[p]][i];
        end
      end
    end
  end

  // Registered read ports; disabled lanes keep their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        rdata_r[p]  <= {LW{1'b0}};
        rvalid_r[p] <= 1'b0;
      end
    end else if (state_r == ST_READY) begin
      for (int p = 0; p < 2; p++) begin
        rvalid_r[p] <= |ren_s[p];
        for (int i = 0; i < NUM_LANES; i++) begin
          if (ren_s[p][i]) begin
            rdata_r[p][i*DATA_W +: DATA_W] <= rnext_s[p][i*DATA_W +: DATA_W];
          end
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalid_r[p] <= 1'b0;
      end
    end
  end

  assign busy     = busy_r;
  assign rdata_0  = rdata_r[0];
  assign rdata_1  = rdata_r[1];
  assign rvalid_0 = rvalid_r[0];
  assign rvalid_1 = rvalid_r[1];

endmodule

// File: doc/warp_regfile_param.md
Name: warp_regfile_param

Overview:
- Parametrised successor to the fixed 16-warp/16-lane/16-register register block.
- Per-lane, per-warp register storage with two registered read ports and one per-lane-masked write port.
- Read warp and write warp are selected independently.
- Adds an optional write-to-read bypass and a post-reset hardware clear sequencer that zeroes all storage.
- Sits between warp scheduler/operand collector and the lane ALUs.

Parameters:
NUM_WARPS, 16, number of warp contexts (power of 2, >=2)
NUM_LANES, 16, SIMD lanes per warp
NUM_REGS, 16, architectural registers per lane per warp (power of 2, >=2)
DATA_W, 32, register width in bits
BYPASS, 1, 1 = same-cycle write forwarded to reads; 0 = reads return pre-write contents
WW, $clog2(NUM_WARPS), derived, warp index width
AW, $clog2(NUM_REGS), derived, register address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
busy  out  1  clear sequencer active; reads/writes ignored
read_en_0  in  NUM_LANES  per-lane read enable, port 0
read_en_1  in  NUM_LANES  per-lane read enable, port 1
raddr_0  in  AW  register address, port 0
raddr_1  in  AW  register address, port 1
rwarp  in  WW  warp selected for both read ports
write_en  in  NUM_LANES  per-lane write enable
waddr  in  AW  write register address
wwarp  in  WW  warp selected for write
wdata  in  NUM_LANES*DATA_W  write data; lane i at [i*DATA_W +: DATA_W]
rdata_0  out  NUM_LANES*DATA_W  port 0 read data, same lane packing
rdata_1  out  NUM_LANES*DATA_W  port 1 read data
rvalid_0  out  1  port 0 data updated this cycle
rvalid_1  out  1  port 1 data updated this cycle

Behaviour:
- Reset (rst=1 at posedge):
  - rdata_0/1 <= 0, rvalid_0/1 <= 0, busy <= 1.
  - Clear counter <= 0; FSM -> CLEAR.
  - Reset asserted mid-CLEAR restarts the counter from 0.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to all lanes of row {warp=cnt[WW+AW-1:AW], reg=cnt[AW-1:0]}, then cnt++.
  - CLEAR exits when the row at cnt = NUM_WARPS*NUM_REGS-1 is written. FSM -> READY and busy <= 0 on that same edge.
  - CLEAR length is NUM_WARPS*NUM_REGS cycles after rst drops (256 at defaults).
  - While busy: write_en, read_en_0 and read_en_1 are ignored; rdata holds 0 and rvalid = 0.
- Write (READY):
  - At posedge, for every lane i with write_en[i]=1, mem[wwarp][waddr][i] <= wdata lane i.
  - Lanes with write_en[i]=0 are untouched.
- Read (READY), 1-cycle latency:
  - At posedge, lane i of rdata_p <= mem[rwarp][raddr_p][i] if read_en_p[i]=1; otherwise lane i holds its previous value.
  - rvalid_p <= |read_en_p.
- Ports 0 and 1 are fully independent and may read the same address simultaneously.
- Bypass:
  - Applies when a read and write occur in the same cycle with rwarp==wwarp, raddr_p==waddr, read_en_p[i]=1 and write_en[i]=1.
  - BYPASS=1: lane i of rdata_p returns wdata lane i.
  - BYPASS=0: lane i returns the old contents.
  - Lanes not being written always return stored contents.
- Different-warp writes never affect reads; no bypass is applied.
- Address and warp indices are exact; no wrap-around occurs within an access.
- No X on outputs after reset: storage is fully defined after CLEAR.

Test Plan:
- Reset/clear: hold rst 2 cycles then release. Required: busy=1 for exactly 256 cycles. Write 32'hDEADBEEF during busy, then read after busy falls: reads 0.
- All-lane write/read sweep over every warp and register: write_en=16'hFFFF, random wdata; next cycle read_en_0=read_en_1=16'hFFFF at the same address/warp. Required: both ports return written data 1 cycle later, rvalid_0=rvalid_1=1.
- Lane mask: write_en=16'h00FF, wdata all lanes 32'hA5A5A5A5 over prior 32'h11111111. Required: lanes 0-7 read 32'hA5A5A5A5, lanes 8-15 read 32'h11111111.
- Bypass: same-cycle write 32'h12345678 and read of warp 3, reg 5. Required: with BYPASS=1 the read returns 32'h12345678. With BYPASS=0 it returns the old value; the following read returns 32'h12345678.
- Warp isolation: write wwarp=2, reg 7 = 32'hCAFEF00D. Required: read rwarp=9, reg 7 returns 0. Required: read rwarp=2, reg 7 returns 32'hCAFEF00D.
- Reset mid-clear: assert rst at clear cycle 100. Required: busy stays high for a full 256 cycles after release. Required: read_en_0=0 holds rdata and gives rvalid_0=0.
